// File: rtl/selector_pkg.sv
// Shared definitions for the nibble selector family: source mode encoding and
// the lane slicing helper used to locate a lane's field inside a packed vector.
package selector_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // LSB position of lane 'lane' inside a vector of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/selector_lane.sv
// One output lane: picks a NIB_W field from word A or B. In SCAN mode the
// lane's base index is offset by the running scan count, wrapping mod NIBS.
module selector_lane
  import selector_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4,
  parameter int IDX_W  = 3
) (
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [IDX_W-1:0]  idx_a,
  input  logic [IDX_W-1:0]  idx_b,
  input  logic              sel,
  input  logic              mode,
  input  logic [IDX_W-1:0]  scan_cnt,
  output logic [NIB_W-1:0]  nib
);

  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word;

  // Source/index selection; the IDX_W-bit add gives the mod-NIBS wrap for free.
  always_comb begin
    base = sel ? idx_b : idx_a;
    idx  = (mode == MODE_SCAN) ? base + scan_cnt : base;
    word = sel ? data_b : data_a;
    nib  = word[idx*NIB_W +: NIB_W];
  end

endmodule

// File: rtl/nibble_selector_n.sv
// Flow-controlled nibble selector: LANES lanes each select one field from
// DATA_A/DATA_B, results buffered in an output register plus a skid register
// so IN_READY depends on registered state only.
module nibble_selector_n
  import selector_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4,
  parameter int LANES  = 4
) (
  input  logic                                        CLK,
  input  logic                                        RESET_L,
  input  logic                                        IN_VALID,
  output logic                                        IN_READY,
  input  logic [DATA_W-1:0]                           DATA_A,
  input  logic [DATA_W-1:0]                           DATA_B,
  input  logic [LANES*$clog2(DATA_W/NIB_W)-1:0]       SEL_A,
  input  logic [LANES*$clog2(DATA_W/NIB_W)-1:0]       SEL_B,
  input  logic [LANES-1:0]                            SEL,
  input  logic                                        MODE,
  output logic                                        OUT_VALID,
  input  logic                                        OUT_READY,
  output logic [LANES*NIB_W-1:0]                      NIBBLE_OUT,
  output logic                                        SCAN_WRAP
);

  localparam int NIBS  = DATA_W / NIB_W;
  localparam int IDX_W = $clog2(NIBS);

  if ((DATA_W % NIB_W) != 0 || NIBS < 2 || (NIBS & (NIBS - 1)) != 0) begin : g_param_check
    $error("nibble_selector_n: DATA_W/NIB_W must be an integral power of two >= 2");
  end

  logic [IDX_W-1:0]       scan_cnt_p1;
  logic [LANES*NIB_W-1:0] sel_nib_p0;
  logic                   sel_wrap_p0;
  logic [LANES*NIB_W-1:0] out_nib_p1;
  logic                   out_wrap_p1;
  logic                   out_vld_p1;
  logic [LANES*NIB_W-1:0] skid_nib_p1;
  logic                   skid_wrap_p1;
  logic                   skid_vld_p1;
  logic                   accept;
  logic                   xfer;

  assign accept = IN_VALID && !skid_vld_p1;
  assign xfer   = out_vld_p1 && OUT_READY;

  // ---- stage p0: combinational selection at accept time ----
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int SLSB = lane_lsb(i, IDX_W);
    localparam int NLSB = lane_lsb(i, NIB_W);
    selector_lane #(
      .DATA_W (DATA_W),
      .NIB_W  (NIB_W),
      .IDX_W  (IDX_W)
    ) u_lane (
      .data_a   (DATA_A),
      .data_b   (DATA_B),
      .idx_a    (SEL_A[SLSB +: IDX_W]),
      .idx_b    (SEL_B[SLSB +: IDX_W]),
      .sel      (SEL[i]),
      .mode     (MODE),
      .scan_cnt (scan_cnt_p1),
      .nib      (sel_nib_p0[NLSB +: NIB_W])
    );
  end

  // NIBS is a power of two, so a count of NIBS-1 is all ones.
  assign sel_wrap_p0 = (MODE == MODE_SCAN) && (&scan_cnt_p1);

  // Scan counter: advances on accepted SCAN beats, clears on accepted DIRECT beats.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      scan_cnt_p1 <= '0;
    end else if (accept) begin
      scan_cnt_p1 <= (MODE == MODE_SCAN) ? scan_cnt_p1 + IDX_W'(1) : '0;
    end
  end

  // ---- stage p1: output register and skid register ----
  // Skid drains into the output register first; a new beat fills whichever slot is free.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      out_vld_p1   <= 1'b0;
      out_nib_p1   <= '0;
      out_wrap_p1  <= 1'b0;
      skid_vld_p1  <= 1'b0;
      skid_nib_p1  <= '0;
      skid_wrap_p1 <= 1'b0;
    end else if (!out_vld_p1 || xfer) begin
      if (skid_vld_p1) begin
        out_vld_p1  <= 1'b1;
        out_nib_p1  <= skid_nib_p1;
        out_wrap_p1 <= skid_wrap_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        out_vld_p1  <= 1'b1;
        out_nib_p1  <= sel_nib_p0;
        out_wrap_p1 <= sel_wrap_p0;
      end else begin
        out_vld_p1  <= 1'b0;
      end
    end else if (accept) begin
      skid_vld_p1  <= 1'b1;
      skid_nib_p1  <= sel_nib_p0;
      skid_wrap_p1 <= sel_wrap_p0;
    end
  end

  assign IN_READY   = !skid_vld_p1;
  assign OUT_VALID  = out_vld_p1;
  assign NIBBLE_OUT = out_nib_p1;
  assign SCAN_WRAP  = out_wrap_p1;

endmodule

// File: doc/nibble_selector_n.md
# nibble_selector_n

Parametrised, flow-controlled successor to the four-lane nibble selector. Each of `LANES` output lanes picks one `NIB_W`-bit field from `DATA_A` or `DATA_B`. The block adds a registered valid/ready pipeline with a skid buffer and a SCAN mode that walks the field index automatically. It sits between the word sources and the nibble consumers (display/serialiser path), one cycle downstream of the sources.

## Interface
- `DATA_W`, default 32: input word width; must be a multiple of `NIB_W`.
- `NIB_W`, default 4: field width per lane.
- `LANES`, default 4: number of output lanes.
- Derived localparams:
  - `NIBS = DATA_W/NIB_W`; must be a power of two, checked at elaboration.
  - `IDX_W = $clog2(NIBS)`.
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RESET_L`  in  1  asynchronous, active-low reset.
- `IN_VALID`  in  1  input beat present.
- `IN_READY`  out  1  block can accept a beat.
- `DATA_A`, `DATA_B`  in  `DATA_W` each  source words.
- `SEL_A`, `SEL_B`  in  `LANES*IDX_W` each  per-lane field index; lane i uses `[i*IDX_W +: IDX_W]`.
- `SEL`  in  `LANES`  per-lane source: 0 = A, 1 = B.
- `MODE`  in  1  0 = DIRECT, 1 = SCAN; sampled only on an accepted beat.
- `OUT_VALID`  out  1  output beat present.
- `OUT_READY`  in  1  consumer accepts.
- `NIBBLE_OUT`  out  `LANES*NIB_W`  lane i at `[i*NIB_W +: NIB_W]`.
- `SCAN_WRAP`  out  1  sideband carried with the beat: marks the last beat of a scan cycle.

## Operation
- Field k of a word is bits `[k*NIB_W +: NIB_W]`; field 0 is the LSBs.
- Accept: `IN_VALID && IN_READY`. Output transfer: `OUT_VALID && OUT_READY`.
- Index for lane i:
  - DIRECT: `base_i`, where `base_i` is the lane's `SEL_A` or `SEL_B` field, chosen by `SEL[i]`.
  - SCAN: `(base_i + scan_cnt) mod NIBS`. The addition wraps naturally in `IDX_W` bits.
- `scan_cnt` (`IDX_W` bits) changes only on accepted beats:
  - SCAN beat: the beat captures the current count, then the counter increments, wrapping from `NIBS-1` to 0.
  - DIRECT beat: the counter clears to 0.
- `SCAN_WRAP` is set on a SCAN beat whose captured count is `NIBS-1`. It is 0 on every DIRECT beat.
- Buffering uses a 2-entry structure: output register plus skid register.
  - Beats leave in arrival order. No beat is dropped or duplicated.
  - The selection result is computed combinationally at accept time. Only results are stored, never raw inputs.
  - `IN_READY = !skid_valid`, registered state only. There is no combinational path from `OUT_READY` to `IN_READY`.
  - If an accept occurs while the output register is full and not transferring, the beat goes to the skid register.
  - On a transfer, the skid register (if valid) moves to the output register. In the same cycle, any new accept goes to whichever register is free in order.
- Reset (`RESET_L` low, asynchronous):
  - `OUT_VALID`=0, `skid_valid`=0, `IN_READY`=1, `NIBBLE_OUT`=0, `SCAN_WRAP`=0, `scan_cnt`=0.
  - In-flight beats are discarded.
  - Inputs are ignored while `RESET_L` is low.

## Timing
- Latency: 1 cycle. A beat accepted at edge n drives `OUT_VALID`/`NIBBLE_OUT` after edge n when the output stage is empty.
- Throughput: 1 beat/cycle with `OUT_READY` held high.
- With `OUT_READY` low: at most 2 beats are accepted. `IN_READY` falls in the cycle after the second accept. It rises in the cycle after the first transfer.
- Simultaneous transfer and accept with both registers full cannot occur, because `IN_READY`=0 in that state.
- Reset assertion takes effect immediately, with no clock needed. Release is synchronised externally. The first accept can occur on the first edge after release.

## Structure
- Shared package `selector_pkg`:
  - `MODE_DIRECT` = 1'b0, `MODE_SCAN` = 1'b1.
  - Index-packing helper for lane slicing, shared with the older selectors.
- Sub-module `selector_lane`: purely combinational. Takes the two words, two indices, the source select, mode and count, and returns one `NIB_W` field. It is instantiated `LANES` times via generate.
- Top level holds the counter, skid buffer and handshake.

## Test plan
- DIRECT, `DATA_A`=32'h76543210, `DATA_B`=32'hFEDCBA98:
  - `SEL`=0, `SEL_A` lane i = i: `NIBBLE_OUT`=16'h3210 one cycle after accept.
  - `SEL`=4'hF, `SEL_B` lane i = 7-i: `NIBBLE_OUT`=16'hCDEF.
- SCAN, `SEL`=0, `SEL_A` all 0, `OUT_READY`=1, 9 beats:
  - Outputs 16'h0000, 16'h1111 … 16'h7777, then 16'h0000.
  - `SCAN_WRAP`=1 only on the 16'h7777 beat.
- Backpressure: `OUT_READY`=0, `IN_VALID` held for 3 cycles:
  - Two beats accepted; `IN_READY` low after the second.
  - Raise `OUT_READY`: both beats emerge in order, then the third is accepted. Sequence intact.
- Mode switch: 3 SCAN beats (counts 0,1,2), one DIRECT beat, then SCAN again. The next SCAN beat uses count 0.
- Async reset mid-stream, asserted between edges with both registers full:
  - `OUT_VALID` and `SCAN_WRAP` drop and `IN_READY` rises without a clock edge.
  - After release, the first SCAN beat uses count 0.
- Parameters `DATA_W`=32, `NIB_W`=8, `LANES`=2 (`IDX_W`=2), `DATA_A`=32'hDDCCBBAA, `SEL_A`={2'd3, 2'd1}, `SEL`=0: `NIBBLE_OUT`=16'hDDBB.
